// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word length and mode constants.
// Used by spi_slave and the companion master.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_W_DEFAULT      = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  // Mode 0, MSB first.
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_MSB_FIRST = 1'b1;

  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous input, with optional registered
// rise/fall strobes (one clk wide, STAGES+1 clk after the input edge).
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0,
  parameter bit   EDGE_EN  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{IDLE_LVL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q, prev_d;
      logic rise_q, rise_d;
      logic fall_q, fall_d;

      always_comb begin
        prev_d = dout;
        rise_d = dout & ~prev_q;
        fall_d = ~dout & prev_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prev_q <= IDLE_LVL;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
          rise_q <= rise_d;
          fall_q <= fall_d;
        end
      end

      assign rise = rise_q;
      assign fall = fall_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampling sclk/chip_sel in the clk domain.
// Optional SPI_SLAVE_OVERRUN_EN adds the rx_overrun flag output.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              chip_sel,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic              rx_overrun
`endif
);

  localparam int CNT_W = spi_cnt_w(DATA_W);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .dout  (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1), .EDGE_EN(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (chip_sel),
    .dout  (cs_lvl_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (mosi),
    .dout  (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              miso_q, miso_d;
  logic              word_done;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic              overrun_q, overrun_d;
`endif

  assign word_done = (state_q == ST_ACTIVE) && (cnt_q == CNT_W'(DATA_W));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ack;
    tx_ready_d = 1'b0;
    miso_d     = miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    overrun_d  = overrun_q & ~rx_ack;
`endif

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          miso_d     = tx_data[DATA_W-1];
          tx_sh_d    = tx_data << 1;
          tx_ready_d = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end else if (word_done) begin
          // Completion wins over a same-cycle acknowledge.
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          tx_sh_d    = tx_data;
          tx_ready_d = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
          if (rx_valid_q && !rx_ack) begin
            overrun_d = 1'b1;
          end
`endif
        end else begin
          if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end
          // tx_sh holds the bits still to be shown; after a wrap it holds the
          // whole new word so the next fall presents its MSB.
          if (sclk_fall) begin
            miso_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign rx_overrun = overrun_q;
`endif

  assign miso_oe  = (state_q == ST_ACTIVE);
  assign miso     = miso_q & miso_oe;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, hand sequences for
// select abort / overwrite / reset, and randomized transfers against a word-level model.
module tb_spi_slave;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         chip_sel;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ack = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic         rx_overrun;
`endif

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .chip_sel (chip_sel),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .rx_overrun (rx_overrun)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Consumer side: counts tx_ready pulses and rx_valid events, optionally acks.
  int           txr_cnt    = 0;
  int           vld_events = 0;
  logic         vld_prev   = 1'b0;
  logic         auto_ack   = 1'b1;
  logic         man_ack    = 1'b0;
  logic [W-1:0] rx_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (tx_ready) txr_cnt++;
      if (rx_valid && !vld_prev) vld_events++;
      vld_prev = rx_valid;
      if (auto_ack && rx_valid && !rx_ack) begin
        rx_log.push_back(rx_data);
        rx_ack = 1'b1;
      end else begin
        rx_ack = man_ack;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sel();
    @(negedge clk);
    chip_sel = 1'b0;
    #100;
  endtask

  task automatic desel();
    @(negedge clk);
    chip_sel = 1'b1;
    #100;
  endtask

  // Master side: nbits mode-0 bits, miso captured just before each sclk rise.
  task automatic xfer_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[W-1-i];
      #50;
      mi   = {mi[W-2:0], miso};
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
  endtask

  // Word-level model: the first n bits the master sees are the top n bits of tx.
  function automatic logic [W-1:0] exp_miso_bits(input logic [W-1:0] tx, input int n);
    return tx >> (W - n);
  endfunction

  task automatic chk_rx_log(input string name, input int base, input logic [W-1:0] exp[$]);
    chk({name, "_count"}, rx_log.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < rx_log.size()) chk({name, "_word"}, rx_log[base + i], exp[i]);
    end
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] mo;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
  } vec_t;

  vec_t         vecs[5];
  logic [W-1:0] mi;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rx;
  int           base, t0, e0;

  initial begin
    vecs[0] = '{tx: 8'hA5, mo: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{tx: 8'h00, mo: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[2] = '{tx: 8'hFF, mo: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[3] = '{tx: 8'h81, mo: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81};
    vecs[4] = '{tx: 8'h3C, mo: 8'hA5, exp_rx: 8'hA5, exp_miso: 8'h3C};

    reset    = 1'b1;
    sclk     = 1'b0;
    chip_sel = 1'b1;
    mosi     = 1'b0;
    tx_data  = '0;
    #23;
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("rst_overrun", rx_overrun, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #100;
    chk("idle_miso_oe", miso_oe, 1'b0);

    // Directed single-word table.
    foreach (vecs[k]) begin
      tx_data = vecs[k].tx;
      base    = rx_log.size();
      t0      = txr_cnt;
      sel();
      chk("vec_miso_oe_sel", miso_oe, 1'b1);
      xfer_bits(vecs[k].mo, W, mi);
      desel();
      chk("vec_miso", mi, vecs[k].exp_miso);
      exp_q = {vecs[k].exp_rx};
      chk_rx_log("vec_rx", base, exp_q);
      chk("vec_tx_ready_pulses", txr_cnt - t0, 2);
      chk("vec_miso_oe_desel", miso_oe, 1'b0);
      chk("vec_miso_desel", miso, 1'b0);
    end

    // Back-to-back words under one select.
    tx_data = 8'h5A;
    base    = rx_log.size();
    t0      = txr_cnt;
    e0      = vld_events;
    sel();
    xfer_bits(8'h12, W, mi);
    chk("b2b_miso0", mi, 8'h5A);
    xfer_bits(8'h34, W, mi);
    chk("b2b_miso1", mi, 8'h5A);
    desel();
    exp_q = {8'h12, 8'h34};
    chk_rx_log("b2b_rx", base, exp_q);
    chk("b2b_tx_ready_pulses", txr_cnt - t0, 3);
    chk("b2b_valid_events", vld_events - e0, 2);

    // Select dropped after 5 bits: word discarded, next word clean.
    last_rx = rx_data;
    base    = rx_log.size();
    e0      = vld_events;
    tx_data = 8'hC6;
    sel();
    xfer_bits(8'hC3, 5, mi);
    desel();
    chk("part_miso", mi, exp_miso_bits(8'hC6, 5));
    chk("part_valid_events", vld_events - e0, 0);
    chk("part_rx_valid", rx_valid, 1'b0);
    chk("part_rx_data", rx_data, last_rx);
    tx_data = 8'h69;
    sel();
    xfer_bits(8'hFF, W, mi);
    desel();
    chk("after_part_miso", mi, 8'h69);
    exp_q = {8'hFF};
    chk_rx_log("after_part_rx", base, exp_q);

    // Two words without acknowledge: second overwrites.
    auto_ack = 1'b0;
    tx_data  = 8'h0F;
    sel();
    xfer_bits(8'h11, W, mi);
    chk("ovr_valid_first", rx_valid, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("ovr_flag_first", rx_overrun, 1'b0);
`endif
    xfer_bits(8'h22, W, mi);
    desel();
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_rx_data", rx_data, 8'h22);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("ovr_flag", rx_overrun, 1'b1);
`endif
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("ack_clears_valid", rx_valid, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("ack_clears_overrun", rx_overrun, 1'b0);
`endif

    // Acknowledge held through completion: the new word still flags valid.
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    e0      = vld_events;
    tx_data = 8'h96;
    sel();
    xfer_bits(8'h5C, W, mi);
    desel();
    chk("ackhold_miso", mi, 8'h96);
    chk("ackhold_valid_events", vld_events - e0, 1);
    chk("ackhold_rx_data", rx_data, 8'h5C);
    chk("ackhold_valid_cleared", rx_valid, 1'b0);
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    auto_ack = 1'b1;

    // Reset in the middle of a word.
    tx_data = 8'hE7;
    sel();
    xfer_bits(8'hAA, 3, mi);
    #23;
    reset = 1'b1;
    #1;
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_miso_oe", miso_oe, 1'b0);
    chk("midrst_tx_ready", tx_ready, 1'b0);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chip_sel = 1'b1;
    sclk     = 1'b0;
    #40;
    @(negedge clk);
    reset = 1'b0;
    #100;
    chk("postrst_idle", miso_oe, 1'b0);
    base    = rx_log.size();
    tx_data = 8'h7E;
    sel();
    xfer_bits(8'h81, W, mi);
    desel();
    chk("postrst_miso", mi, 8'h7E);
    exp_q = {8'h81};
    chk_rx_log("postrst_rx", base, exp_q);

    // Randomized selects: 1-3 whole words, optional trailing partial word.
    for (int it = 0; it < 12; it++) begin
      logic [W-1:0] tx, mo;
      int nw, pb;
      tx      = W'($urandom);
      nw      = int'($urandom_range(1, 3));
      pb      = int'($urandom_range(0, 7));
      tx_data = tx;
      base    = rx_log.size();
      t0      = txr_cnt;
      exp_q.delete();
      last_rx = rx_data;
      sel();
      for (int w = 0; w < nw; w++) begin
        mo = W'($urandom);
        xfer_bits(mo, W, mi);
        chk("rnd_miso", mi, tx);
        exp_q.push_back(mo);
        last_rx = mo;
      end
      if (pb > 0) begin
        mo = W'($urandom);
        xfer_bits(mo, pb, mi);
        chk("rnd_part_miso", mi, exp_miso_bits(tx, pb));
      end
      desel();
      chk_rx_log("rnd_rx", base, exp_q);
      chk("rnd_rx_data", rx_data, last_rx);
      chk("rnd_tx_ready_pulses", txr_cnt - t0, 1 + nw);
      chk("rnd_miso_oe_idle", miso_oe, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving word length in bits (legal 4..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving synchronizer depth for sclk, cs_n and mosi (legal 2..3).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 The block SHALL have port chip_sel  input  1  active-low slave select from master.
REQ-007 The block SHALL have port mosi  input  1  master-to-slave serial data.
REQ-008 The block SHALL have port miso  output  1  slave-to-master serial data.
REQ-009 The block SHALL have port miso_oe  output  1  miso drive enable, high only while selected.
REQ-010 The block SHALL have port tx_data  input  DATA_W  next word to transmit.
REQ-011 The block SHALL have port tx_ready  output  1  one-cycle pulse when tx_data has been captured.
REQ-012 The block SHALL have port rx_data  output  DATA_W  last complete received word.
REQ-013 The block SHALL have port rx_valid  output  1  rx_data holds an unacknowledged word.
REQ-014 The block SHALL have port rx_ack  input  1  consumer acknowledge, clears rx_valid.

Function
REQ-015 The block SHALL operate in SPI mode 0, MSB first: mosi sampled on sclk rise, miso updated on sclk fall.
REQ-016 The block SHALL detect sclk/chip_sel edges from synchronized samples; each detected edge is a one-clk strobe, latency SYNC_STAGES+1 clk cycles.
REQ-017 The block SHALL support sclk frequency up to clk/8; faster sclk is unsupported.
REQ-018 The FSM SHALL have states IDLE (chip_sel high) and ACTIVE (selected, shifting).
REQ-019 IDLE->ACTIVE on synchronized chip_sel fall: shift register loads tx_data, tx_ready pulses, bit counter clears, miso = tx_data[DATA_W-1].
REQ-020 In ACTIVE each sclk-rise strobe SHALL shift mosi into the receive register and increment the bit counter.
REQ-021 In ACTIVE each sclk-fall strobe SHALL present the next transmit bit on miso.
REQ-022 When the counter reaches DATA_W, on the next clk: rx_data updates, rx_valid sets, counter wraps to 0, tx_data reloads and tx_ready pulses (back-to-back words, no gap).
REQ-023 rx_ack with rx_valid high SHALL clear rx_valid next cycle; a word completing in the same cycle as rx_ack SHALL win (rx_valid stays 1, new data).
REQ-024 ACTIVE->IDLE on synchronized chip_sel rise; a partial word SHALL be discarded, no rx_valid, counter cleared.
REQ-025 miso_oe SHALL equal the synchronized selected state; miso SHALL be 0 when miso_oe is 0.

Reset
REQ-026 reset SHALL asynchronously force IDLE, counter 0, miso 0, miso_oe 0, tx_ready 0, rx_valid 0, rx_data 0, synchronizers to idle levels (sclk 0, chip_sel 1).
REQ-027 Reset mid-word SHALL discard the word; after release the block waits for a fresh chip_sel fall.

Configuration
REQ-028 Macro SPI_SLAVE_OVERRUN_EN, when defined, SHALL add output rx_overrun (1 bit), set when a word completes while rx_valid is high without same-cycle rx_ack, cleared by reset or rx_ack; new data overwrites rx_data.
REQ-029 Without SPI_SLAVE_OVERRUN_EN the port SHALL be absent and overwrite is silent.

Structure
REQ-030 Package file spi_pkg SHALL hold the FSM state encodings, default DATA_W and SPI mode constants, shared with the master.
REQ-031 Sub-module spi_sync SHALL implement the SYNC_STAGES synchronizer plus rise/fall strobes, instantiated for sclk and chip_sel (mosi synchronizer only).

Verification
REQ-032 clk 100 MHz, sclk 10 MHz, tx_data=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1.
REQ-033 Two back-to-back words 8'h12, 8'h34 with chip_sel held low -> two rx_valid events, tx_ready pulses three times (select + 2 wraps).
REQ-034 chip_sel rises after 5 bits -> no rx_valid, rx_data unchanged, next transfer of 8'hFF received correctly.
REQ-035 With SPI_SLAVE_OVERRUN_EN, two words without rx_ack -> rx_overrun=1, rx_data=second word; rx_ack clears both.
REQ-036 reset asserted mid-word (bit 3) -> all outputs at reset values within same cycle; subsequent 8'h81 transfer correct.
